// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage. Owns the HI/LO registers and runs
// mult/multu/div/divu/madd/maddu/msub/msubu over a fixed number of busy
// cycles; mthi/mtlo write HI/LO in a single edge with no busy window.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears all state
//   start  - EX instruction is MDU-class and not stalled/flushed
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//            6 madd, 7 maddu, 8 msub, 9 msubu, 10-15 no-op
//   A, B   - rs / rt operands
//   busy   - operation in flight (registered)
//   HI, LO - HI and LO registers
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {StIdle, StRun} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        sgn;
   logic [63:0] a_ext, b_ext, prod, acc;
   logic        a_neg, b_neg;
   logic [31:0] abs_a, abs_b, divisor, uq, ur, quo, rem;

   // Signed flavours: mult, div, madd, msub.
   assign sgn   = (op_q == 4'd0) || (op_q == 4'd2) || (op_q == 4'd6) || (op_q == 4'd8);
   assign a_ext = {{32{sgn & a_q[31]}}, a_q};
   assign b_ext = {{32{sgn & b_q[31]}}, b_q};
   // Low 64 bits of the sign/zero-extended product are the correct result either way.
   assign prod  = a_ext * b_ext;
   assign acc   = {hi_q, lo_q};

   // Division on magnitudes, signs restored afterwards. This also yields the
   // wrapped 0x80000000 quotient for 0x80000000 / -1 without special-casing.
   assign a_neg   = sgn & a_q[31];
   assign b_neg   = sgn & b_q[31];
   assign abs_a   = a_neg ? (~a_q + 32'd1) : a_q;
   assign abs_b   = b_neg ? (~b_q + 32'd1) : b_q;
   assign divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;  // result discarded when B is zero
   assign uq      = abs_a / divisor;
   assign ur      = abs_a % divisor;
   assign quo     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
   assign rem     = a_neg ? (~ur + 32'd1) : ur;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (op)
                  4'd4: hi_d = A;
                  4'd5: lo_d = A;
                  4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9: begin
                     op_d    = op;
                     a_d     = A;
                     b_d     = B;
                     cnt_d   = ((op == 4'd2) || (op == 4'd3)) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                     state_d = StRun;
                  end
                  default: ;
               endcase
            end
         end
         StRun: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StIdle;
               case (op_q)
                  4'd0, 4'd1: {hi_d, lo_d} = prod;
                  4'd2, 4'd3: begin
                     if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                     end
                  end
                  4'd6, 4'd7: {hi_d, lo_d} = acc + prod;
                  4'd8, 4'd9: {hi_d, lo_d} = acc - prod;
                  default: ;
               endcase
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == StRun);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage MIPS pipeline. It sits in EX beside the ALU and executes every instruction the decode stage classifies as multiply/divide/HI-LO (mult, multu, div, divu, madd, maddu, msub, msubu, mthi, mtlo). It owns the HI and LO registers and exposes `busy` so the hazard controller can stall MDU-class instructions (including mfhi/mflo) while an operation is in flight.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  EX-stage instruction is MDU-class and not stalled/flushed
- `op`  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu; 10–15 no-op
- `A`  in  32  rs operand (forwarded value)
- `B`  in  32  rt operand (forwarded value)
- `busy`  out  1  operation in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- State: IDLE / RUN; 4-bit down-counter `cnt`; latched `op_q`, `A_q`, `B_q`; HI, LO registers.
- Reset (async, any state): HI=0, LO=0, busy=0, cnt=0, state IDLE; any in-flight result is discarded.
- IDLE, `start`=1, op 4 (mthi): HI←A at that edge; stays IDLE. op 5 (mtlo): LO←A. busy stays 0.
- IDLE, `start`=1, op 0–3 or 6–9: latch op/A/B, cnt←MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, `start`=1, op 10–15: ignored.
- RUN: cnt decrements each edge; on the edge where cnt==1, write result, go IDLE.
- `start` while RUN: ignored (hazard controller guarantees it never happens; bench checks no state change).
- Results (64-bit {HI,LO}, arithmetic modulo 2^64):
  - mult: signed A×B; multu: unsigned A×B.
  - div: LO = signed quotient truncated toward zero; HI = remainder with sign of dividend. divu: unsigned quotient/remainder.
  - div/divu with B_q==0: HI and LO unchanged; busy timing identical.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - madd/maddu: {HI,LO} + product (signed/unsigned); msub/msubu: {HI,LO} − product. The {HI,LO} used is the value at result-write time.
- HI/LO outputs are the registers directly; no bypass of in-flight results.

## Timing
- `start` sampled at edge t (IDLE): busy=1 during cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES), HI/LO updated at the edge closing cycle t+N, visible with busy=0 from cycle t+N+1.
- Back-to-back: a new `start` may be sampled at the edge where busy falls (first IDLE cycle, t+N+1); no dead cycle required.
- mthi/mtlo: new HI/LO visible the cycle after the sampling edge; zero busy cycles.
- `busy` is a registered output; no combinational path from `start` to `busy`.
- Reset asserted mid-RUN: busy drops and HI/LO read 0 without waiting for a clock; after release, first `start` behaves as from IDLE.

## Test plan
- Reset then mult A=0xFFFFFFFE (−2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles; second multu started at the busy-fall edge completes 5 cycles later.
- div A=0xFFFFFFF9 (−7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 with HI=0x11, LO=0x22 preloaded -> unchanged.
- mthi A=0x12345678 then mtlo A=1 in consecutive cycles, then madd A=2, B=3 -> busy never set for mthi/mtlo; final HI=0x12345678, LO=7. msubu A=1, B=8 on {0,7} -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- start pulsed with mult while busy from a div -> ignored; div result correct, no second busy window.
- Assert reset at cycle 3 of a div, asynchronous to clk -> busy, HI, LO are 0 before next edge; post-reset mult A=4, B=5 -> LO=20, HI=0.
